// File: rtl/seq_serializer_pkg.sv
// ---------------------------------------------------------------------------
// seq_serializer_pkg
//
// Purpose: definitions shared by the serializer and its sub-module.
//   - DEFAULT_WIDTH : default parallel word width
//   - ser_state_t   : FSM state encoding (IDLE / SHIFT / PARITY)
//
// PARITY is always part of the encoding. The serializer only enters it
// when SER_PARITY_EN is defined.
// ---------------------------------------------------------------------------
package seq_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } ser_state_t;

endpackage

// File: rtl/seq_serializer_parity_gen.sv
// ---------------------------------------------------------------------------
// parity_gen
//
// Purpose: combinational even-parity generator (XOR reduction of a word).
//
// Ports:
//   data   in  [WIDTH-1:0]  word to reduce
//   parity out 1            XOR of all bits of data
//
// This block is instantiated only when SER_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module parity_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/seq_serializer.sv
// ---------------------------------------------------------------------------
// seq_serializer
//
// Purpose: parallel-to-serial front end for the sequence detector. The block
// accepts WIDTH-bit words over a valid/ready handshake and shifts them out one
// bit per clock on seq. Words sent back to back produce a gap-free bitstream.
// While idle, seq is 0, which clears the downstream detector's run count.
//
// Parameters:
//   WIDTH     data word width (minimum 2)
//   MSB_FIRST 1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   din        in   parallel word, sampled only on accept
//   din_valid  in   producer has a word on din
//   din_ready  out  block can take a word this cycle
//   seq        out  serial bit to the detector
//   seq_valid  out  seq carries a data or parity bit
//   busy       out  a word is in flight (state is not IDLE)
//   frame_done out  pulse on the cycle the final bit of a word is on seq
//
// Configuration macro:
//   SER_PARITY_EN  when defined, an even-parity bit follows the data bits,
//                  so each frame is WIDTH+1 bits long
// ---------------------------------------------------------------------------
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             seq,
  output logic             seq_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  ser_state_t       state;
  ser_state_t       next_state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             cur_bit;
  logic             accept;

  // The bit on seq always comes from a fixed end of the shift register,
  // because the register shifts toward that end after every presented bit.
  assign last_bit = (cnt == LAST_IDX);
  assign cur_bit  = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
  assign accept   = din_valid && din_ready;

`ifdef SER_PARITY_EN
  logic word_parity;
  logic parity_bit;

  parity_gen #(
    .WIDTH (WIDTH)
  ) u_parity_gen (
    .data   (din),
    .parity (word_parity)
  );

  // Parity is captured at accept time. The shift register no longer holds
  // the original word by the time the parity cycle arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= word_parity;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A word accepted on the final-bit cycle goes straight
  // back into SHIFT, so there is no gap between frames.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef SER_PARITY_EN
          next_state = PARITY;
`else
          next_state = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        next_state = accept ? SHIFT : IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Output logic. Outputs depend only on registered state, so there is no
  // combinational path from din_valid to any output.
  always_comb begin
    din_ready  = 1'b0;
    seq        = 1'b0;
    seq_valid  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
      end
      SHIFT: begin
        seq       = cur_bit;
        seq_valid = 1'b1;
        busy      = 1'b1;
`ifndef SER_PARITY_EN
        din_ready  = last_bit;
        frame_done = last_bit;
`endif
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        seq        = parity_bit;
        seq_valid  = 1'b1;
        busy       = 1'b1;
        din_ready  = 1'b1;
        frame_done = 1'b1;
      end
`endif
      default: begin
        din_ready = 1'b0;
      end
    endcase
  end

  // Shift register and bit counter. The counter wraps to 0 after the last
  // bit, so it never exceeds WIDTH-1 even when WIDTH is not a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      cnt       <= '0;
    end else if (accept) begin
      shift_reg <= din;
      cnt       <= '0;
    end else if (state == SHIFT) begin
      if (MSB_FIRST) begin
        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      end else begin
        shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
      end
      cnt <= last_bit ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_serializer
//
// Directed bench for seq_serializer (WIDTH=8, MSB_FIRST=1). Every driven word
// that the reference model expects to be accepted pushes its bits into a
// queue. Each cycle, the bench compares the DUT outputs with the head of
// that queue. The reference model's own idea of readiness decides when a
// word is accepted. Honors SER_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_seq_serializer;

  localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef struct packed {
    logic bit_val;
    logic last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             seq;
  logic             seq_valid;
  logic             busy;
  logic             frame_done;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  seq_serializer #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .seq        (seq),
    .seq_valid  (seq_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Compare all outputs with the head of the expected-bit queue
  task automatic checkOutput();
    logic e_seq, e_valid, e_done, e_busy, e_ready;
    if (exp_q.size() > 0) begin
      e_seq   = exp_q[0].bit_val;
      e_valid = 1'b1;
      e_done  = exp_q[0].last;
      e_busy  = 1'b1;
    end else begin
      e_seq   = 1'b0;
      e_valid = 1'b0;
      e_done  = 1'b0;
      e_busy  = 1'b0;
    end
    e_ready = (exp_q.size() <= 1);
    checkValue("seq", seq, e_seq);
    checkValue("seq_valid", seq_valid, e_valid);
    checkValue("frame_done", frame_done, e_done);
    checkValue("busy", busy, e_busy);
    checkValue("din_ready", din_ready, e_ready);
  endtask

  task automatic pushWord(input logic [WIDTH-1:0] w);
    exp_t e;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      e.bit_val = w[i];
      e.last    = (i == 0);
`ifdef SER_PARITY_EN
      e.last    = 1'b0;
`endif
      exp_q.push_back(e);
    end
`ifdef SER_PARITY_EN
    e.bit_val = ^w;
    e.last    = 1'b1;
    exp_q.push_back(e);
`endif
  endtask

  // Drive the inputs for the next rising edge and advance the model
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d);
    logic ready_model;
    ready_model = (exp_q.size() <= 1);
    din_valid   = v;
    din         = d;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (v && ready_model) pushWord(d);
  endtask

  task automatic cycle(input logic v, input logic [WIDTH-1:0] d);
    checkOutput();
    applyStimulus(v, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single word, MSB first
    $display("[TB] single word 8'hA5");
    cycle(1'b1, 8'hA5);
    repeat (FRAME + 3) cycle(1'b0, '0);

    // Back-to-back all-ones words span the boundary with no gap
    $display("[TB] back-to-back 8'hFF");
    cycle(1'b1, 8'hFF);
    repeat (FRAME) cycle(1'b1, 8'hFF);
    repeat (FRAME + 3) cycle(1'b0, '0);

    // Stall: valid held high during SHIFT must not disturb the frame
    $display("[TB] stall with 8'h3C pending");
    cycle(1'b1, 8'h96);
    repeat (FRAME) cycle(1'b1, 8'h3C);
    repeat (FRAME + 3) cycle(1'b0, '0);

    // Word with odd parity
    $display("[TB] word 8'h07");
    cycle(1'b1, 8'h07);
    repeat (FRAME + 2) cycle(1'b0, '0);

    // Reset mid-word
    $display("[TB] reset mid-word 8'hF0");
    cycle(1'b1, 8'hF0);
    repeat (4) cycle(1'b0, '0);
    #2 rst = 1'b0;
    #1;
    checkValue("async_rst_seq", seq, 1'b0);
    checkValue("async_rst_seq_valid", seq_valid, 1'b0);
    checkValue("async_rst_busy", busy, 1'b0);
    checkValue("async_rst_frame_done", frame_done, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, '0);
    cycle(1'b1, 8'hC3);
    repeat (FRAME + 3) cycle(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
